// File: rtl/xg_rst_gen.sv
// Reset sequencer for xg_interface: qualifies MMCM lock in the clk50m domain and
// drives a registered system reset, with software reset hold and lock-loss counting.
module xg_rst_gen #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       sw_rst_req,
  output logic       sys_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned CNT_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned HCNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [HCNT_W-1:0]      hcnt, hcnt_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic                   lost_d;
  logic [7:0]             lost_cnt_d;

  assign locked_s = sync[SYNC_STAGES-1];

  // Next state, counters and lock-loss event; outputs follow the new state
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    hcnt_d     = hcnt;
    lost_d     = 1'b0;
    lost_cnt_d = lock_lost_cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s)             state_d = WAIT_LOCK;
        else if (cnt == CNT_LAST)  state_d = RUN;
        else                       cnt_d   = cnt + CNT_W'(1);
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (sw_rst_req) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (hcnt == HCNT_LAST) begin
          state_d = RUN;
        end else begin
          hcnt_d = hcnt + HCNT_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Saturate so a flapping MMCM never wraps the status count back to a small value
    if (lost_d && (lock_lost_cnt != 8'hFF)) lost_cnt_d = lock_lost_cnt + 8'd1;
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      hcnt          <= '0;
      sync          <= '0;
      sys_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      lock_lost     <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      hcnt          <= hcnt_d;
      sync          <= {sync[SYNC_STAGES-2:0], locked_in};
      sys_rst       <= (state_d != RUN);
      sys_rst_n     <= (state_d == RUN);
      ready         <= (state_d == RUN);
      lock_lost     <= lost_d;
      lock_lost_cnt <= lost_cnt_d;
    end
  end

endmodule
